// File: rtl/mem_stage_pkg.sv
// Shared encodings and helpers for the MEM stage: access sizes, FSM states
// and the alignment rule used to reject accesses before they reach the RAM.
package mem_stage_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Size 2'b11 is reserved and always treated as a faulting access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic mis;
      unique case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = addr_lo[0];
         SZ_WORD: mis = (addr_lo != 2'b00);
         default: mis = 1'b1;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/data_ram_be.sv
// Byte-array data RAM, big-endian: the word at A spans bytes A (MSB) .. A+3.
// Combinational 4-byte read, synchronous byte-enabled write.
module data_ram_be
   import mem_stage_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 9
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [1:0]           size,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata
);

   localparam int unsigned Depth = 2 ** ADDR_BITS;

   logic [7:0]           mem_q     [Depth];
   logic [ADDR_BITS-1:0] lane_addr [4];
   logic [7:0]           lane_d    [4];
   logic [3:0]           lane_be;

   // Lane k always targets addr+k; the size picks how many lanes are live.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         lane_addr[k] = addr + ADDR_BITS'(k);
      end
   end

   always_comb begin
      lane_be = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         lane_d[k] = 8'h00;
      end
      unique case (size)
         SZ_BYTE: begin
            lane_be   = 4'b0001;
            lane_d[0] = wdata[7:0];
         end
         SZ_HALF: begin
            lane_be   = 4'b0011;
            lane_d[0] = wdata[15:8];
            lane_d[1] = wdata[7:0];
         end
         SZ_WORD: begin
            lane_be   = 4'b1111;
            lane_d[0] = wdata[31:24];
            lane_d[1] = wdata[23:16];
            lane_d[2] = wdata[15:8];
            lane_d[3] = wdata[7:0];
         end
         default: lane_be = 4'b0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (we) begin
         for (int k = 0; k < 4; k++) begin
            if (lane_be[k]) begin
               mem_q[lane_addr[k]] <= lane_d[k];
            end
         end
      end
   end

   assign rdata = {mem_q[lane_addr[0]], mem_q[lane_addr[1]],
                   mem_q[lane_addr[2]], mem_q[lane_addr[3]]};

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage datapath and MEM/WB pipeline register. Aligned memory accesses
// take MEM_LATENCY cycles and stall upstream; everything else takes one.
module mem_wb_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned ADDR_BITS   = 9,
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  mem_size_in,
   input  logic        mem_se_in,
   input  logic        mem_rw_in,
   input  logic        mem_enable_in,
   input  logic        load_instr_in,
   input  logic        rf_enable_in,
   input  logic [31:0] alu_in,
   input  logic [31:0] pa_in,
   input  logic [4:0]  rd_in,
   output logic        stall,
   output logic        wb_rf_enable,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        misalign_err
);

   localparam logic [2:0] CntLast = 3'(MEM_LATENCY - 1);

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        wb_rf_enable_q, wb_rf_enable_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        misalign_err_q, misalign_err_d;

   logic [ADDR_BITS-1:0] addr;
   logic                 mis_cond;
   logic                 mem_op;
   logic                 done;
   logic                 ram_we;
   logic [31:0]          ram_rdata;
   logic [31:0]          load_fmt;

   assign addr     = alu_in[ADDR_BITS-1:0];
   assign mis_cond = mem_enable_in & is_misaligned(mem_size_in, addr[1:0]);
   assign mem_op   = mem_enable_in & ~mis_cond;

   // An accepted access completes either immediately (single-cycle RAM) or
   // on the last counted BUSY cycle.
   always_comb begin
      done = 1'b0;
      if (mem_op) begin
         if (state_q == IDLE) begin
            done = (MEM_LATENCY == 1);
         end else begin
            done = (cnt_q == CntLast);
         end
      end
   end

   assign stall  = ~reset & mem_op & ~done;
   assign ram_we = ~reset & done & mem_rw_in;

   data_ram_be #(
      .ADDR_BITS(ADDR_BITS)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .size (mem_size_in),
      .addr (addr),
      .wdata(pa_in),
      .rdata(ram_rdata)
   );

   always_comb begin
      unique case (mem_size_in)
         SZ_BYTE: load_fmt = {{24{mem_se_in & ram_rdata[31]}}, ram_rdata[31:24]};
         SZ_HALF: load_fmt = {{16{mem_se_in & ram_rdata[31]}}, ram_rdata[31:16]};
         default: load_fmt = ram_rdata;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (mem_op && !done) begin
               state_d = BUSY;
               cnt_d   = 3'd1;
            end
         end
         BUSY: begin
            if (cnt_q == CntLast) begin
               state_d = IDLE;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   // Default is a bubble; stalled cycles fall through to it.
   always_comb begin
      wb_rf_enable_d = 1'b0;
      wb_rd_d        = 5'd0;
      wb_data_d      = 32'd0;
      misalign_err_d = 1'b0;
      if (mis_cond) begin
         misalign_err_d = 1'b1;
      end else if (!mem_enable_in) begin
         wb_rf_enable_d = rf_enable_in;
         wb_rd_d        = rd_in;
         wb_data_d      = alu_in;
      end else if (done) begin
         wb_rf_enable_d = rf_enable_in;
         wb_rd_d        = rd_in;
         if (!mem_rw_in && load_instr_in) begin
            wb_data_d = load_fmt;
         end else begin
            wb_data_d = alu_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= 3'd0;
         wb_rf_enable_q <= 1'b0;
         wb_rd_q        <= 5'd0;
         wb_data_q      <= 32'd0;
         misalign_err_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         wb_rf_enable_q <= wb_rf_enable_d;
         wb_rd_q        <= wb_rd_d;
         wb_data_q      <= wb_data_d;
         misalign_err_q <= misalign_err_d;
      end
   end

   assign wb_rf_enable = wb_rf_enable_q;
   assign wb_rd        = wb_rd_q;
   assign wb_data      = wb_data_q;
   assign misalign_err = misalign_err_q;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM-stage datapath plus MEM/WB pipeline register. It consumes the EX/MEM register outputs: size/sign/rw/enable controls, ALU result used as address, store data and destination register. It performs byte, halfword and word loads and stores into a local big-endian data RAM with a configurable access latency. It stalls upstream while an access is in flight and registers the write-back data, rd and enable for the WB stage.

Parameters:
ADDR_BITS, 9, byte-address width of the data RAM (2^ADDR_BITS bytes)
MEM_LATENCY, 2, cycles per memory access, legal range 1..8

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
mem_size_in  input  2  00 byte, 01 halfword, 10 word, 11 reserved
mem_se_in  input  1  1 = sign-extend load, 0 = zero-extend
mem_rw_in  input  1  1 = store, 0 = load
mem_enable_in  input  1  1 = memory operation this cycle
load_instr_in  input  1  1 = write-back data comes from memory
rf_enable_in  input  1  register-file write request
alu_in  input  32  ALU result / effective address
pa_in  input  32  store data (rt value)
rd_in  input  5  destination register
stall  output  1  combinational; 1 = upstream must hold EX/MEM contents
wb_rf_enable  output  1  registered RF write enable for WB
wb_rd  output  5  registered destination register
wb_data  output  32  registered write-back value
misalign_err  output  1  registered one-cycle pulse on misaligned or reserved-size access

Behaviour:
- Reset: synchronous, active-high. All outputs 0 from the first edge with reset=1. FSM goes to IDLE and cnt to 0. stall is forced 0 while reset=1. RAM contents are not cleared, and an in-flight store is aborted (no write).
- Address: addr = alu_in[ADDR_BITS-1:0]. Upper bits are ignored. The RAM is big-endian: the word at addr A is bytes A (MSB) through A+3.
- Misaligned when mem_enable_in=1 and any of:
  - size=01 with addr[0]=1
  - size=10 with addr[1:0]!=00
  - size=11
- Misaligned access handling, at the next edge: misalign_err=1, wb_rf_enable=0, no RAM access, no stall. misalign_err returns to 0 on the following edge unless the condition repeats.
- Non-memory op (mem_enable_in=0): 1-cycle latency, stall=0.
  - wb_rf_enable<=rf_enable_in, wb_rd<=rd_in, wb_data<=alu_in.
- FSM states: IDLE, BUSY. Counter cnt has 3 bits.
  - IDLE, valid aligned mem op, MEM_LATENCY=1: completes at this edge, stall=0, stays IDLE.
  - IDLE, valid aligned mem op, MEM_LATENCY>1: stall=1. At the edge go to BUSY with cnt<=1, and WB registers capture a bubble (wb_rf_enable=0, wb_rd=0, wb_data=0).
  - BUSY: stall=(cnt!=MEM_LATENCY-1). While stall=1, cnt increments at each edge and a bubble is captured. When cnt==MEM_LATENCY-1, the access completes at that edge, FSM returns to IDLE and cnt<=0.
- Upstream holds all inputs stable while stall=1. The block samples the inputs again only at the completion edge.
- Completion, store: exactly one RAM write at the completion edge.
  - byte: pa_in[7:0] to addr
  - halfword: pa_in[15:8] to addr, pa_in[7:0] to addr+1
  - word: pa_in[31:24]..pa_in[7:0] to addr..addr+3
  - WB registers: wb_rf_enable<=rf_enable_in, wb_rd<=rd_in, wb_data<=alu_in.
- Completion, load: RAM read is combinational on addr. The formatted value is registered at the completion edge.
  - byte: se ? {24{b[7]},b} : {24'b0,b}
  - halfword: same rule on 16 bits
  - word: as-is
  - wb_data<=load_instr_in ? formatted : alu_in. wb_rf_enable<=rf_enable_in, wb_rd<=rd_in.
- Load-after-store: the store completes before the next op is accepted, so a following load reads the new data.
- Reset asserted during BUSY: the access is dropped, and the block is IDLE with stall=0 after reset deasserts.

Decomposition:
- Package mem_stage_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - FSM state typedef {IDLE, BUSY}
  - helper function is_misaligned(size, addr[1:0])
- Sub-module data_ram_be: byte-array RAM, 2^ADDR_BITS bytes.
  - combinational 4-byte big-endian read at addr
  - synchronous byte-enable write (we, size, addr, wdata)
  - load formatting and sign extension stay in mem_wb_stage.

Test Plan:
All scenarios use MEM_LATENCY=2.
1. Assert reset 2 cycles -> wb_rf_enable=0, wb_rd=0, wb_data=0, misalign_err=0, stall=0.
2. ALU op: mem_enable_in=0, rf_enable_in=1, rd_in=5, alu_in=0x00001234 -> next edge wb_data=0x00001234, wb_rd=5, wb_rf_enable=1; stall never 1.
3. SW addr 0x010 data 0xDEADBEEF -> stall=1 for exactly 1 cycle, one bubble. Then:
   - LW 0x010 rd=8, load_instr=1 -> wb_data=0xDEADBEEF, wb_rd=8
   - LB se 0x010 -> 0xFFFFFFDE
   - LBU 0x013 -> 0x000000EF
   - LH se 0x012 -> 0xFFFFBEEF
4. SW 0x040 0x11223344, then SB 0x041 pa_in=0x000000AA, then LW 0x040 -> 0x11AA3344.
5. SH addr 0x021 -> misalign_err pulses 1 cycle, stall=0, wb_rf_enable=0. SW 0x022 and size=11 also each pulse. A following LW 0x020 returns the value written before the misaligned attempt.
6. SW 0x030 0xCAFEF00D, then SW 0x030 0x12345678 with reset asserted in its stall cycle -> after reset, LW 0x030 returns 0xCAFEF00D; stall=0 immediately after reset.
